keypad_scanner: RTL and testbench

//  Parametrised matrix-keypad scanner, successor to the fixed 4x4 Input block. Drives one row at a time,

---
 rtl/keypad_scanner.sv | 234 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row drive, frame-level debounce with chord rejection,
// optional auto-repeat, and a first-word-fall-through key-code FIFO with valid/ack.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                            Clock,
    input  logic                            Reset,
    output logic [ROWS-1:0]                 V,
    input  logic [COLS-1:0]                 H,
    input  logic                            rpt_en,
    output logic                            valid,
    output logic [$clog2(ROWS*COLS)-1:0]    cmd,
    input  logic                            ack,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            ovf,
    input  logic                            ovf_clr
);

    localparam int CW = $clog2(ROWS*COLS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int NW = $clog2(DEBOUNCE+1);
    localparam int HW = $clog2(REPEAT_DELAY+1);
    localparam int PW = $clog2(REPEAT_RATE+1);

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_PRESSED, S_REL} state_t;

    logic [COLS-1:0] r_h_s1, r_h_s2;
    logic [SW-1:0]   r_slot;
    logic [RW-1:0]   r_row;
    logic [ROWS-1:0] r_v;
    logic [1:0]      r_fcnt;
    logic [CW-1:0]   r_fcode;

    state_t          r_state;
    logic [CW-1:0]   r_cand;
    logic [NW-1:0]   r_n;
    logic [HW-1:0]   r_hold;
    logic [PW-1:0]   r_rate;
    logic            r_emit;
    logic [CW-1:0]   r_emit_code;

    logic [CW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [AW:0]     r_level;
    logic            r_ovf;

    logic            w_slot_end, w_row_last, w_frame_end;
    logic [1:0]      w_row_cnt, w_tot;
    logic [2:0]      w_sum;
    int unsigned     w_row_col;
    logic [CW-1:0]   w_row_code, w_code;
    logic            w_one, w_hit;
    logic            w_pop, w_full, w_push;

    assign w_slot_end  = (r_slot == SW'(SCAN_DIV-1));
    assign w_row_last  = (r_row == RW'(ROWS-1));
    assign w_frame_end = w_slot_end && w_row_last;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_h_s1 <= '0;
            r_h_s2 <= '0;
            r_slot <= '0;
            r_row  <= '0;
            r_v    <= ROWS'(1);
        end else begin
            r_h_s1 <= H;
            r_h_s2 <= r_h_s1;
            if (w_slot_end) begin
                r_slot <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                    r_v   <= ROWS'(1);
                end else begin
                    r_row <= r_row + 1'b1;
                    r_v   <= {r_v[ROWS-2:0], 1'b0};
                end
            end else begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

    // Per-row hit count saturates at 2; only "exactly one" matters downstream.
    always_comb begin
        w_row_cnt = '0;
        w_row_col = 0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (r_h_s2[c]) begin
                if (w_row_cnt != 2'd2) w_row_cnt = w_row_cnt + 2'd1;
                w_row_col = c;
            end
        end
        w_row_code = CW'(32'(r_row) * COLS + w_row_col);
        w_sum      = {1'b0, r_fcnt} + {1'b0, w_row_cnt};
        w_tot      = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_code     = (r_fcnt == 2'd1) ? r_fcode : w_row_code;
    end

    assign w_one = (w_tot == 2'd1);
    assign w_hit = w_one && (w_code == r_cand);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_fcnt  <= '0;
            r_fcode <= '0;
        end else if (w_slot_end) begin
            r_fcnt  <= w_row_last ? 2'd0 : w_tot;
            r_fcode <= w_code;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cand      <= '0;
            r_n         <= '0;
            r_hold      <= '0;
            r_rate      <= '0;
            r_emit      <= 1'b0;
            r_emit_code <= '0;
        end else begin
            r_emit <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_one) begin
                            r_cand <= w_code;
                            if (DEBOUNCE == 1) begin
                                r_state     <= S_PRESSED;
                                r_emit      <= 1'b1;
                                r_emit_code <= w_code;
                                r_hold      <= '0;
                                r_rate      <= '0;
                            end else begin
                                r_state <= S_DEB;
                                r_n     <= NW'(1);
                            end
                        end
                    end
                    S_DEB: begin
                        if (w_hit) begin
                            if (r_n >= NW'(DEBOUNCE-1)) begin
                                r_state     <= S_PRESSED;
                                r_emit      <= 1'b1;
                                r_emit_code <= r_cand;
                                r_hold      <= '0;
                                r_rate      <= '0;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_PRESSED: begin
                        if (w_hit) begin
                            // Hold count saturates at the delay; the rate counter then paces repeats.
                            if (r_hold != HW'(REPEAT_DELAY)) begin
                                r_hold <= r_hold + 1'b1;
                                if (rpt_en && r_hold == HW'(REPEAT_DELAY-1)) begin
                                    r_emit      <= 1'b1;
                                    r_emit_code <= r_cand;
                                end
                            end else if (r_rate == PW'(REPEAT_RATE-1)) begin
                                r_rate <= '0;
                                if (rpt_en) begin
                                    r_emit      <= 1'b1;
                                    r_emit_code <= r_cand;
                                end
                            end else begin
                                r_rate <= r_rate + 1'b1;
                            end
                        end else begin
                            r_state <= (DEBOUNCE == 1) ? S_IDLE : S_REL;
                            r_n     <= NW'(1);
                        end
                    end
                    S_REL: begin
                        if (w_hit) begin
                            r_state <= S_PRESSED;
                        end else if (w_one) begin
                            r_n <= NW'(1);
                        end else if (r_n >= NW'(DEBOUNCE-1)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_n <= r_n + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_pop  = valid && ack;
    assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_push = r_emit && (!w_full || w_pop);

    always_ff @(posedge Clock) begin
        if (w_push) r_mem[r_wp] <= r_emit_code;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            if (r_emit && !w_push) r_ovf <= 1'b1;
            else if (ovf_clr)      r_ovf <= 1'b0;
        end
    end

    assign V     = r_v;
    assign valid = (r_level != '0);
    assign cmd   = valid ? r_mem[r_rp] : '0;
    assign level = r_level;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives H from V, expected codes are queued
// by the stimulus and a monitor pops/compares them whenever the scanner presents a code.
module tb_keypad_scanner;

    localparam int FRAME = 4 * 16;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] V;
    logic [3:0] H;
    logic       rpt_en = 1'b0;
    logic       valid;
    logic [3:0] cmd;
    logic       ack = 1'b0;
    logic [2:0] level;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    logic [15:0] keymask = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mode = 0;   // 0: no ack, 1: ack every code, 2: single ack aligned to push slot
    int          exp_q[$];

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(16), .DEBOUNCE(3),
        .FIFO_DEPTH(4), .REPEAT_DELAY(32), .REPEAT_RATE(8)
    ) dut (
        .Clock(Clock), .Reset(Reset), .V(V), .H(H), .rpt_en(rpt_en),
        .valid(valid), .cmd(cmd), .ack(ack), .level(level),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always_comb begin
        H = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (V[r] && keymask[r*4+c]) H[c] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) @(posedge Clock);
        #1;
    endtask

    task automatic press(input int code, input int hold);
        keymask = '0;
        keymask[code] = 1'b1;
        frames(hold);
        keymask = '0;
        frames(4);
    endtask

    // Monitor: compares the head code against the scoreboard and acknowledges it.
    initial begin
        forever begin
            @(negedge Clock);
            if (valid && (mode == 1 || (mode == 2 && cyc % FRAME == 0))) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_code: got %0d expected none (t=%0t)", cmd, $time);
                end else begin
                    check("cmd", int'(cmd), exp_q.pop_front());
                end
                ack = 1'b1;
                if (mode == 2) mode = 0;
            end else begin
                ack = 1'b0;
            end
        end
    end

    initial begin
        // T1 reset
        repeat (3) @(posedge Clock);
        #1;
        check("reset_V", int'(V), 1);
        check("reset_valid", int'(valid), 0);
        check("reset_level", int'(level), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_cmd", int'(cmd), 0);
        Reset = 1'b1;
        mode = 1;

        // T2 single press r2c1, no repeat
        exp_q.push_back(9);
        press(9, 5);
        check("t2_level", int'(level), 0);

        // T3 bounce r0c3: 2 on, 1 off, 1 on
        keymask[3] = 1'b1; frames(2);
        keymask = '0;      frames(1);
        keymask[3] = 1'b1; frames(1);
        keymask = '0;      frames(4);
        check("t3_level", int'(level), 0);

        // T4 chord r1c0 + r3c3, then only r1c0
        keymask[4] = 1'b1;
        keymask[15] = 1'b1;
        frames(10);
        check("t4_chord_level", int'(level), 0);
        exp_q.push_back(4);
        keymask[15] = 1'b0;
        frames(3);
        keymask = '0;
        frames(4);

        // T5 auto-repeat r0c0: press, DELAY, DELAY+8, DELAY+16
        rpt_en = 1'b1;
        repeat (4) exp_q.push_back(0);
        press(0, 51);
        rpt_en = 1'b0;
        check("t5_queue_drained", exp_q.size(), 0);

        // T6 overflow: five presses without ack
        mode = 0;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(5);
        press(1, 3);
        press(2, 3);
        press(3, 3);
        press(5, 3);
        press(6, 3);
        check("t6_level_full", int'(level), 4);
        check("t6_ovf", int'(ovf), 1);
        check("t6_head", int'(cmd), 1);

        // Push and pop in the same cycle on a full FIFO
        exp_q.push_back(7);
        keymask[7] = 1'b1;
        repeat (2 * FRAME + 1) @(posedge Clock);
        #1 mode = 2;
        repeat (FRAME - 1) @(posedge Clock);
        repeat (2) @(posedge Clock);
        #1;
        check("t6_level_pushpop", int'(level), 4);
        check("t6_head_after", int'(cmd), 2);
        repeat (FRAME - 2) @(posedge Clock);
        #1;
        keymask = '0;
        frames(4);
        check("t6_ovf_sticky", int'(ovf), 1);
        mode = 1;
        frames(1);
        check("t6_level_drained", int'(level), 0);
        ovf_clr = 1'b1;
        @(posedge Clock);
        #1 ovf_clr = 1'b0;
        check("t6_ovf_clr", int'(ovf), 0);

        // Mid-operation reset discards buffered codes
        mode = 0;
        press(10, 3);
        check("rst_pre_level", int'(level), 1);
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_level", int'(level), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_V", int'(V), 1);
        Reset = 1'b1;
        frames(1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
